// File: rtl/ppb_frame_sched_pkg.sv
// Shared constants, FSM encoding and arbitration helper for the
// ping-pong buffer frame scheduler.
package ppb_frame_sched_pkg;

  localparam int WORD_LEN  = 11;
  localparam int FFT_N     = 32;
  localparam int FILL_CYC  = FFT_N / 2;
  localparam int DRAIN_CYC = FFT_N;
  localparam int NBANK     = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Round-robin pick between two lanes: a lone requester wins, a tie goes to
  // the lane that did not win last time.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/ppb_tag_fifo.sv
// Small 1-bit-wide FIFO holding the source lane of each buffered frame,
// plus its protocol checker.
module ppb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == CW'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  ppb_tag_fifo_chk u_chk (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .full    (full),
    .empty   (empty)
  );

endmodule

// Credit accounting guarantees the FIFO is never pushed while full nor
// popped while empty; these properties flag any violation.
module ppb_tag_fifo_chk (
  input logic clk,
  input logic i_rst_n,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!i_rst_n) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!i_rst_n) !(pop && empty));

endmodule

// File: rtl/ppb_frame_sched.sv
// Frame-level round-robin scheduler in front of the bit-reverse ping-pong
// buffer: grants whole frames, muxes the lane, tracks bank credit and tags.
module ppb_frame_sched #(
  parameter int W         = ppb_frame_sched_pkg::WORD_LEN,
  parameter int FILL_CYC  = ppb_frame_sched_pkg::FILL_CYC,
  parameter int DRAIN_CYC = ppb_frame_sched_pkg::DRAIN_CYC,
  parameter int NBANK     = ppb_frame_sched_pkg::NBANK
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] up0,
  input  logic [W-1:0] dn0,
  input  logic [W-1:0] up1,
  input  logic [W-1:0] dn1,
  output logic         rdy0,
  output logic         rdy1,
  output logic         buf_in_valid,
  output logic [W-1:0] buf_up,
  output logic [W-1:0] buf_dn,
  input  logic         buf_out_valid,
  output logic         out_src,
  output logic [1:0]   free_banks,
  output logic         busy,
  output logic         err
);

  import ppb_frame_sched_pkg::*;

  localparam int FC_W = $clog2(FILL_CYC);
  localparam int DC_W = $clog2(DRAIN_CYC);
  localparam logic [FC_W-1:0] FILL_LAST  = FC_W'(FILL_CYC - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);
  localparam logic [1:0]      NBANK_V    = 2'(NBANK);

  state_e            state_r;
  state_e            state_s;
  logic [FC_W-1:0]   fill_cnt_r;
  logic [DC_W-1:0]   drain_cnt_r;
  logic              sel_r;
  logic              last_gnt_r;
  logic [1:0]        free_r;
  logic [1:0]        free_s;
  logic              err_r;

  logic              fill_s;
  logic              fill_last_s;
  logic              can_grant_s;
  logic              grant_s;
  logic              winner_s;
  logic              credit_s;
  logic              tag_head_s;
  logic              tag_full_s;
  logic              tag_empty_s;

  assign fill_s      = (state_r == ST_FILL);
  assign fill_last_s = (fill_cnt_r == FILL_LAST);
  assign winner_s    = pick_winner(req0, req1, last_gnt_r);
  // Credit is read only from the register, so a drain completing this cycle
  // cannot enable a grant until the next one.
  assign can_grant_s = (req0 || req1) && (free_r != 2'd0) && !tag_full_s;
  assign credit_s    = buf_out_valid && !tag_empty_s && (drain_cnt_r == DRAIN_LAST);

  // Next-state and grant decision; grants happen only on frame boundaries.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (can_grant_s) begin
          state_s = ST_FILL;
          grant_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_last_s) begin
          if (can_grant_s) begin
            state_s = ST_FILL;
            grant_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fill counter wraps at the frame boundary so back-to-back frames stay unbroken.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt_r <= {FC_W{1'b0}};
    end else if (fill_s) begin
      fill_cnt_r <= fill_last_s ? {FC_W{1'b0}} : fill_cnt_r + FC_W'(1);
    end else begin
      fill_cnt_r <= {FC_W{1'b0}};
    end
  end

  // Granted lane; last_gnt starts at 1 so lane 0 wins the first tie.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_r      <= 1'b0;
      last_gnt_r <= 1'b1;
    end else if (grant_s) begin
      sel_r      <= winner_s;
      last_gnt_r <= winner_s;
    end else begin
      sel_r      <= sel_r;
      last_gnt_r <= last_gnt_r;
    end
  end

  // Bank credit: debit on grant, credit on last drain word, saturating both ways.
  always_comb begin
    free_s = free_r;
    case ({grant_s, credit_s})
      2'b10:   free_s = (free_r != 2'd0) ? free_r - 2'd1 : free_r;
      2'b01:   free_s = (free_r != NBANK_V) ? free_r + 2'd1 : free_r;
      default: free_s = free_r;
    endcase
  end

  // Credit register, drain word counter and sticky underrun error.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      free_r      <= NBANK_V;
      drain_cnt_r <= {DC_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      free_r <= free_s;
      if (buf_out_valid) begin
        drain_cnt_r <= drain_cnt_r + DC_W'(1);
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
      err_r <= err_r || (buf_out_valid && tag_empty_s);
    end
  end

  ppb_tag_fifo #(
    .DEPTH (NBANK)
  ) u_tag_fifo (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .push    (grant_s),
    .din     (winner_s),
    .pop     (credit_s),
    .dout    (tag_head_s),
    .full    (tag_full_s),
    .empty   (tag_empty_s)
  );

  assign rdy0         = fill_s && !sel_r;
  assign rdy1         = fill_s && sel_r;
  assign buf_in_valid = fill_s;
  assign buf_up       = fill_s ? (sel_r ? up1 : up0) : {W{1'b0}};
  assign buf_dn       = fill_s ? (sel_r ? dn1 : dn0) : {W{1'b0}};
  assign out_src      = tag_empty_s ? 1'b0 : tag_head_s;
  assign free_banks   = free_r;
  assign busy         = fill_s || (free_r != NBANK_V);
  assign err          = err_r;

endmodule
